// File: rtl/axi_portal_hub.sv
// AXI3-lite slave fanning host reads/writes out to NUM_PORTALS request/indication portals.
// Build option: define AXI_PORTAL_SLVERR_EN to answer out-of-range portal accesses with SLVERR.
module axi_portal_hub #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = 6,
  parameter int NUM_PORTALS = 2,
  parameter int IND_DEPTH = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic AR__ENA,
  output logic AR__RDY,
  input  logic [31:0] AR_addr,
  input  logic [ID_WIDTH-1:0] AR_id,
  input  logic [3:0] AR_len,
  input  logic AW__ENA,
  output logic AW__RDY,
  input  logic [31:0] AW_addr,
  input  logic [ID_WIDTH-1:0] AW_id,
  input  logic [3:0] AW_len,
  input  logic W__ENA,
  output logic W__RDY,
  input  logic [DATA_WIDTH-1:0] W_data,
  input  logic W_last,
  output logic R__ENA,
  input  logic R__RDY,
  output logic [DATA_WIDTH-1:0] R_data,
  output logic [ID_WIDTH-1:0] R_id,
  output logic R_last,
  output logic [1:0] R_resp,
  output logic B__ENA,
  input  logic B__RDY,
  output logic [ID_WIDTH-1:0] B_id,
  output logic [1:0] B_resp,
  output logic [NUM_PORTALS-1:0] req__ENA,
  input  logic [NUM_PORTALS-1:0] req__RDY,
  output logic [DATA_WIDTH-1:0] req_v,
  output logic req_last,
  input  logic [NUM_PORTALS-1:0] ind__ENA,
  input  logic [NUM_PORTALS*DATA_WIDTH-1:0] ind_v,
  output logic [NUM_PORTALS-1:0] ind__RDY,
  output logic interrupt
);
  localparam int PW = NUM_PORTALS > 1 ? $clog2(NUM_PORTALS) : 1;
  localparam int QW = $clog2(IND_DEPTH);
  localparam int CW = QW + 1;
  localparam logic [4:0] STEP = 5'((DATA_WIDTH / 8) % 32);
`ifdef AXI_PORTAL_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  typedef enum logic {R_IDLE, R_BURST} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} wstate_t;

  logic [DATA_WIDTH-1:0] mem [NUM_PORTALS][IND_DEPTH];
  logic [QW-1:0] wptr [NUM_PORTALS];
  logic [QW-1:0] rptr [NUM_PORTALS];
  logic [CW-1:0] cnt [NUM_PORTALS];
  logic [NUM_PORTALS-1:0] int_en, nonempty, enq, deq;

  rstate_t r_state;
  logic [2:0] r_p;
  logic r_ctrl, r_pop, pop_now;
  logic [4:0] r_off;
  logic [3:0] r_cnt;
  logic [PW-1:0] r_pi;

  wstate_t w_state;
  logic [2:0] w_p;
  logic w_ctrl, w_ok, w_fwd, w_hs;
  logic [4:0] w_off;
  logic [3:0] w_cnt;
  logic [PW-1:0] w_pi;
  logic [NUM_PORTALS-1:0] w_sel;

  logic [2:0] nb_p;
  logic nb_ctrl, nb_ok, nb_pop;
  logic [4:0] nb_off;
  logic [PW-1:0] nb_pi;
  logic [CW-1:0] nb_cnt;
  logic [QW-1:0] nb_ptr;
  logic [DATA_WIDTH-1:0] nb_head, nb_data;
  logic [1:0] nb_resp;

  logic unused_ok;
  assign unused_ok = ^{AR_addr[31:15], AW_addr[31:15], W_last};

  assign r_pi = r_p[PW-1:0];
  assign pop_now = R__ENA && R__RDY && r_pop;
  assign AR__RDY = r_state == R_IDLE;

  // Next beat is built from the AR fields when idle, else from the burst
  // state, seeing the FIFO as it stands after any pop on this edge.
  always_comb begin
    nb_p = r_p;
    nb_ctrl = r_ctrl;
    nb_off = r_off + STEP;
    if (r_state == R_IDLE) begin
      nb_p = AR_addr[14:12];
      nb_ctrl = AR_addr[11:5] == 7'd0;
      nb_off = AR_addr[4:0];
    end
    nb_ok = {29'd0, nb_p} < 32'(NUM_PORTALS);
    nb_pi = nb_ok ? nb_p[PW-1:0] : '0;
    nb_ptr = rptr[nb_pi] + QW'(pop_now);
    nb_cnt = cnt[nb_pi] - CW'(pop_now);
    nb_head = mem[nb_pi][nb_ptr];
    nb_data = '0;
    nb_pop = 1'b0;
    nb_resp = 2'b00;
    if (!nb_ok) begin
      nb_resp = ERR_RESP;
    end else if (nb_ctrl) begin
      case (nb_off)
        5'd0: nb_data = DATA_WIDTH'(nb_cnt != '0);
        5'd4: nb_data = DATA_WIDTH'(int_en[nb_pi]);
        5'd8: nb_data = DATA_WIDTH'(nb_cnt);
        5'd12: nb_data = DATA_WIDTH'(NUM_PORTALS);
        5'd16: nb_data = DATA_WIDTH'(nb_p);
        default: nb_data = '0;
      endcase
    end else if (nb_off == 5'd0) begin
      if (nb_cnt != '0) begin
        nb_data = nb_head;
        nb_pop = 1'b1;
      end
    end else if (nb_off == 5'd4) begin
      nb_data = DATA_WIDTH'(req__RDY[nb_pi]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= R_IDLE;
      r_p <= '0;
      r_ctrl <= 1'b0;
      r_off <= '0;
      r_cnt <= '0;
      r_pop <= 1'b0;
      R__ENA <= 1'b0;
      R_data <= '0;
      R_id <= '0;
      R_last <= 1'b0;
      R_resp <= 2'b00;
    end else if (r_state == R_IDLE) begin
      if (AR__ENA) begin
        r_state <= R_BURST;
        r_p <= nb_p;
        r_ctrl <= nb_ctrl;
        r_off <= nb_off;
        r_cnt <= AR_len;
        r_pop <= nb_pop;
        R__ENA <= 1'b1;
        R_data <= nb_data;
        R_id <= AR_id;
        R_last <= AR_len == 4'd0;
        R_resp <= nb_resp;
      end
    end else if (R__RDY) begin
      if (r_cnt == 4'd0) begin
        r_state <= R_IDLE;
        r_pop <= 1'b0;
        R__ENA <= 1'b0;
        R_data <= '0;
        R_last <= 1'b0;
        R_resp <= 2'b00;
      end else begin
        r_cnt <= r_cnt - 4'd1;
        r_off <= nb_off;
        r_pop <= nb_pop;
        R_data <= nb_data;
        R_last <= r_cnt == 4'd1;
        R_resp <= nb_resp;
      end
    end
  end

  assign w_ok = {29'd0, w_p} < 32'(NUM_PORTALS);
  assign w_pi = w_ok ? w_p[PW-1:0] : '0;
  assign w_fwd = w_ok && !w_ctrl;
  assign AW__RDY = w_state == W_IDLE;
  assign W__RDY = w_state == W_BURST && (!w_fwd || req__RDY[w_pi]);
  assign w_hs = W__ENA && W__RDY;
  assign req__ENA = (w_hs && w_fwd) ? w_sel : '0;
  assign req_v = W_data;
  assign req_last = w_cnt == 4'd0;

  always_comb begin
    w_sel = '0;
    w_sel[w_pi] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_state <= W_IDLE;
      w_p <= '0;
      w_ctrl <= 1'b0;
      w_off <= '0;
      w_cnt <= '0;
      int_en <= '0;
      B__ENA <= 1'b0;
      B_id <= '0;
      B_resp <= 2'b00;
    end else begin
      unique case (w_state)
        W_IDLE: if (AW__ENA) begin
          w_state <= W_BURST;
          w_p <= AW_addr[14:12];
          w_ctrl <= AW_addr[11:5] == 7'd0;
          w_off <= AW_addr[4:0];
          w_cnt <= AW_len;
          B_id <= AW_id;
        end
        W_BURST: if (w_hs) begin
          if (w_ok && w_ctrl && w_off == 5'd4) int_en[w_pi] <= W_data[0];
          w_off <= w_off + STEP;
          w_cnt <= w_cnt - 4'd1;
          if (w_cnt == 4'd0) begin
            w_state <= W_RESP;
            B__ENA <= 1'b1;
            B_resp <= w_ok ? 2'b00 : ERR_RESP;
          end
        end
        W_RESP: if (B__RDY) begin
          w_state <= W_IDLE;
          B__ENA <= 1'b0;
          B_resp <= 2'b00;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    ind__RDY = '0;
    enq = '0;
    deq = '0;
    nonempty = '0;
    for (int i = 0; i < NUM_PORTALS; i++) begin
      ind__RDY[i] = cnt[i] != CW'(IND_DEPTH);
      enq[i] = ind__ENA[i] && ind__RDY[i];
      deq[i] = pop_now && r_pi == PW'(i);
      nonempty[i] = cnt[i] != '0;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_PORTALS; i++)
      if (enq[i]) mem[i][wptr[i]] <= ind_v[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_PORTALS; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i] <= '0;
      end
      interrupt <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PORTALS; i++) begin
        if (enq[i]) wptr[i] <= wptr[i] + QW'(1);
        if (deq[i]) rptr[i] <= rptr[i] + QW'(1);
        if (enq[i] && !deq[i]) cnt[i] <= cnt[i] + CW'(1);
        else if (deq[i] && !enq[i]) cnt[i] <= cnt[i] - CW'(1);
      end
      interrupt <= |(nonempty & int_en);
    end
  end
endmodule

// File: tb/tb_axi_portal_hub.sv
// Scoreboard bench for axi_portal_hub: expected R beats, req strobes and B
// responses are queued at stimulus time and checked as the DUT emits them.
module tb_axi_portal_hub;
`ifdef AXI_PORTAL_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  typedef struct {
    logic [31:0] data;
    logic [5:0] id;
    logic last;
    logic [1:0] resp;
  } rbeat_t;
  typedef struct {
    logic [1:0] ena;
    logic [31:0] v;
    logic last;
  } req_t;
  typedef struct {
    logic [5:0] id;
    logic [1:0] resp;
  } bresp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic ar_ena = 0, ar_rdy, aw_ena = 0, aw_rdy;
  logic [31:0] ar_addr = 0, aw_addr = 0;
  logic [5:0] ar_id = 0, aw_id = 0;
  logic [3:0] ar_len = 0, aw_len = 0;
  logic w_ena = 0, w_rdy, w_last = 0;
  logic [31:0] w_data = 0;
  logic r_ena, r_rdy = 1, r_last;
  logic [31:0] r_data;
  logic [5:0] r_id, b_id;
  logic [1:0] r_resp, b_resp;
  logic b_ena, b_rdy = 1;
  logic [1:0] req_ena, req_rdy = 2'b11;
  logic [31:0] req_v;
  logic req_last;
  logic [1:0] ind_ena = 0, ind_rdy;
  logic [63:0] ind_v = 0;
  logic irq;

  axi_portal_hub dut (
    .CLK(clk), .RST(rst),
    .AR__ENA(ar_ena), .AR__RDY(ar_rdy), .AR_addr(ar_addr),
    .AR_id(ar_id), .AR_len(ar_len),
    .AW__ENA(aw_ena), .AW__RDY(aw_rdy), .AW_addr(aw_addr),
    .AW_id(aw_id), .AW_len(aw_len),
    .W__ENA(w_ena), .W__RDY(w_rdy), .W_data(w_data), .W_last(w_last),
    .R__ENA(r_ena), .R__RDY(r_rdy), .R_data(r_data), .R_id(r_id),
    .R_last(r_last), .R_resp(r_resp),
    .B__ENA(b_ena), .B__RDY(b_rdy), .B_id(b_id), .B_resp(b_resp),
    .req__ENA(req_ena), .req__RDY(req_rdy), .req_v(req_v),
    .req_last(req_last),
    .ind__ENA(ind_ena), .ind_v(ind_v), .ind__RDY(ind_rdy),
    .interrupt(irq)
  );

  int n_tests = 0;
  int n_fail = 0;
  rbeat_t rq[$];
  req_t qq[$];
  bresp_t bq[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshakes are sampled at the negedge ahead of the edge that completes them.
  always @(negedge clk) begin
    rbeat_t rb;
    req_t rr;
    bresp_t bb;
    if (!rst && r_ena && r_rdy) begin
      if (rq.size() == 0) chk("r_unexpected", 64'(1), 64'(0));
      else begin
        rb = rq.pop_front();
        chk("r_data", 64'(r_data), 64'(rb.data));
        chk("r_id", 64'(r_id), 64'(rb.id));
        chk("r_last", 64'(r_last), 64'(rb.last));
        chk("r_resp", 64'(r_resp), 64'(rb.resp));
      end
    end
    if (!rst && req_ena != 2'b00) begin
      if (qq.size() == 0) chk("req_unexpected", 64'(req_ena), 64'(0));
      else begin
        rr = qq.pop_front();
        chk("req_ena", 64'(req_ena), 64'(rr.ena));
        chk("req_v", 64'(req_v), 64'(rr.v));
        chk("req_last", 64'(req_last), 64'(rr.last));
      end
    end
    if (!rst && b_ena && b_rdy) begin
      if (bq.size() == 0) chk("b_unexpected", 64'(1), 64'(0));
      else begin
        bb = bq.pop_front();
        chk("b_id", 64'(b_id), 64'(bb.id));
        chk("b_resp", 64'(b_resp), 64'(bb.resp));
      end
    end
  end

  task automatic push_r(input logic [31:0] d, input logic [5:0] id,
                        input logic last, input logic [1:0] resp);
    rbeat_t rb;
    rb.data = d; rb.id = id; rb.last = last; rb.resp = resp;
    rq.push_back(rb);
  endtask

  task automatic push_q(input logic [31:0] v, input logic last);
    req_t rr;
    rr.ena = 2'b01; rr.v = v; rr.last = last;
    qq.push_back(rr);
  endtask

  task automatic push_b(input logic [5:0] id, input logic [1:0] resp);
    bresp_t bb;
    bb.id = id; bb.resp = resp;
    bq.push_back(bb);
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [5:0] id,
                         input logic [3:0] len);
    int k = 0;
    ar_addr = a; ar_id = id; ar_len = len; ar_ena = 1'b1;
    do begin @(negedge clk); k++; end while (!ar_rdy && k < 50);
    if (!ar_rdy) chk("ar_timeout", 64'(0), 64'(1));
    @(posedge clk); #1 ar_ena = 1'b0;
    chk("r_ena_next", 64'(r_ena), 64'(1));
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [5:0] id,
                         input logic [3:0] len);
    int k = 0;
    aw_addr = a; aw_id = id; aw_len = len; aw_ena = 1'b1;
    do begin @(negedge clk); k++; end while (!aw_rdy && k < 50);
    if (!aw_rdy) chk("aw_timeout", 64'(0), 64'(1));
    @(posedge clk); #1 aw_ena = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic last);
    int k = 0;
    w_data = d; w_last = last; w_ena = 1'b1;
    do begin @(negedge clk); k++; end while (!w_rdy && k < 50);
    if (!w_rdy) chk("w_timeout", 64'(0), 64'(1));
    @(posedge clk); #1 w_ena = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((rq.size() + qq.size() + bq.size()) != 0 && k < 100) begin
      @(posedge clk); k++;
    end
    chk("drain", 64'(rq.size() + qq.size() + bq.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ar_rdy", 64'(ar_rdy), 64'(1));
    chk("rst_aw_rdy", 64'(aw_rdy), 64'(1));
    chk("rst_w_rdy", 64'(w_rdy), 64'(0));
    chk("rst_r_ena", 64'(r_ena), 64'(0));
    chk("rst_b_ena", 64'(b_ena), 64'(0));
    chk("rst_req_ena", 64'(req_ena), 64'(0));
    chk("rst_ind_rdy", 64'(ind_rdy), 64'(2'b11));
    chk("rst_irq", 64'(irq), 64'(0));
    chk("rst_r_data", 64'(r_data), 64'(0));
    chk("rst_b_resp", 64'(b_resp), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // intEnable[1] set, then indication on portal 1 raises interrupt
    push_b(6'd3, 2'b00);
    aw_send(32'h1004, 6'd3, 4'd0);
    w_beat(32'h1, 1'b1);
    chk("b_after_w", 64'(b_ena), 64'(1));
    drain();
    ind_ena = 2'b10; ind_v = {32'hA5A5A5A5, 32'h0};
    @(posedge clk); #1 ind_ena = 2'b00;
    chk("irq_1cyc", 64'(irq), 64'(0));
    @(posedge clk); #1;
    chk("irq_2cyc", 64'(irq), 64'(1));
    push_r(32'h1, 6'd2, 1'b1, 2'b00);
    ar_send(32'h1004, 6'd2, 4'd0);
    push_r(32'hA5A5A5A5, 6'd5, 1'b1, 2'b00);
    ar_send(32'h1020, 6'd5, 4'd0);
    drain();
    @(posedge clk); #1;
    chk("irq_clear", 64'(irq), 64'(0));

    // empty FIFO burst read, req__RDY[0] low
    req_rdy = 2'b10;
    push_r(32'h0, 6'd9, 1'b0, 2'b00);
    push_r(32'h0, 6'd9, 1'b0, 2'b00);
    push_r(32'h0, 6'd9, 1'b0, 2'b00);
    push_r(32'h0, 6'd9, 1'b1, 2'b00);
    ar_send(32'h0020, 6'd9, 4'd3);
    drain();

    // write burst stalled by portal backpressure
    push_q(32'h1, 1'b0);
    push_q(32'h2, 1'b0);
    push_q(32'h3, 1'b1);
    push_b(6'd7, 2'b00);
    aw_send(32'h0040, 6'd7, 4'd2);
    w_data = 32'h1; w_last = 1'b0; w_ena = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("w_stall", 64'(w_rdy), 64'(0));
      chk("req_stall", 64'(req_ena), 64'(0));
    end
    @(posedge clk); #1 req_rdy = 2'b11;
    w_beat(32'h1, 1'b0);
    w_beat(32'h2, 1'b0);
    w_beat(32'h3, 1'b1);
    chk("b_next", 64'(b_ena), 64'(1));
    drain();

    // fill portal 0, enqueue while full is dropped, pop frees a slot
    for (int i = 0; i < 4; i++) begin
      ind_ena = 2'b01; ind_v = {32'h0, 32'h100 + 32'(i)};
      @(posedge clk); #1;
    end
    ind_ena = 2'b00;
    chk("full_rdy", 64'(ind_rdy), 64'(2'b10));
    ind_ena = 2'b01; ind_v = {32'h0, 32'hDEAD};
    @(posedge clk); #1 ind_ena = 2'b00;
    r_rdy = 1'b0;
    push_r(32'h100, 6'd1, 1'b1, 2'b00);
    ar_send(32'h0020, 6'd1, 4'd0);
    repeat (3) begin
      @(negedge clk);
      chk("r_hold", 64'(r_data), 64'(32'h100));
      chk("no_pop_yet", 64'(ind_rdy), 64'(2'b10));
    end
    @(posedge clk); #1 r_rdy = 1'b1;
    @(posedge clk); #1;
    chk("pop_rdy", 64'(ind_rdy), 64'(2'b11));
    push_r(32'h3, 6'd1, 1'b1, 2'b00);
    ar_send(32'h0008, 6'd1, 4'd0);
    push_r(32'h101, 6'd1, 1'b1, 2'b00);
    ar_send(32'h0020, 6'd1, 4'd0);
    push_r(32'h2, 6'd6, 1'b0, 2'b00);
    push_r(32'h1, 6'd6, 1'b1, 2'b00);
    ar_send(32'h100C, 6'd6, 4'd1);
    push_r(32'h0, 6'd6, 1'b1, 2'b00);
    ar_send(32'h1000, 6'd6, 4'd0);
    push_r(32'h1, 6'd6, 1'b1, 2'b00);
    ar_send(32'h0000, 6'd6, 4'd0);
    drain();

    // out-of-range portal
    push_r(32'h0, 6'd4, 1'b0, ERR);
    push_r(32'h0, 6'd4, 1'b1, ERR);
    ar_send(32'h7000, 6'd4, 4'd1);
    push_b(6'd8, ERR);
    aw_send(32'h7040, 6'd8, 4'd1);
    w_beat(32'h55, 1'b0);
    w_beat(32'h66, 1'b1);
    drain();

    // reset during the second beat of a burst
    push_r(32'h1, 6'h11, 1'b0, 2'b00);
    push_r(32'h0, 6'h11, 1'b0, 2'b00);
    push_r(32'h0, 6'h11, 1'b0, 2'b00);
    push_r(32'h0, 6'h11, 1'b1, 2'b00);
    ar_send(32'h0024, 6'h11, 4'd3);
    @(posedge clk); #1;
    chk("beat2_up", 64'(r_ena), 64'(1));
    rst = 1'b1;
    #1;
    chk("abort_r_ena", 64'(r_ena), 64'(0));
    chk("abort_ind_rdy", 64'(ind_rdy), 64'(2'b11));
    chk("abort_r_data", 64'(r_data), 64'(0));
    rq.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_r_ena", 64'(r_ena), 64'(0));
      chk("post_rst_ar_rdy", 64'(ar_rdy), 64'(1));
    end
    chk("left_r", 64'(rq.size()), 64'(0));
    chk("left_q", 64'(qq.size()), 64'(0));
    chk("left_b", 64'(bq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
